// File: rtl/sh2_ext_bus_bridge_pkg.sv
// sh2_ext_bus_bridge_pkg: shared types for the SH7604 external-bus bridge.
//   state_e   - bridge FSM states (IDLE, BUSY, DONE)
//   mem_req_t - request fields latched at the start of a CPU bus cycle
//   area_t    - encoded chip-select area plus valid flag
//   area_enc  - active-high select vector to lowest-index area
package sh2_ext_bus_bridge_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic [26:0] a;
        logic [1:0]  area;
        logic [31:0] dout;
        logic [3:0]  be;
        logic        wr;
    } mem_req_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } area_t;

    // Lowest asserted select wins when several are active.
    function automatic area_t area_enc(input logic [3:0] sel);
        area_enc.valid = |sel;
        area_enc.idx   = sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sh2_ext_bus_bridge_if.sv
// sh2_ext_bus_bridge_if: CPU bus pins plus generic memory port of the bridge.
//   CPU side : CE_R, CE_F, A, DO, DI, BS_N, CS0_N..CS3_N, RD_WR_N, RD_N, WE_N, WAIT_N
//   Mem side : MEM_A, MEM_AREA, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, MEM_DI, MEM_ACK
//   Status   : TO_ERR
//   slave  = bridge view, master = CPU/memory environment view
interface sh2_ext_bus_bridge_if;
    logic        CE_R;
    logic        CE_F;
    logic [26:0] A;
    logic [31:0] DO;
    logic [31:0] DI;
    logic        BS_N;
    logic        CS0_N;
    logic        CS1_N;
    logic        CS2_N;
    logic        CS3_N;
    logic        RD_WR_N;
    logic        RD_N;
    logic [3:0]  WE_N;
    logic        WAIT_N;
    logic [26:0] MEM_A;
    logic [1:0]  MEM_AREA;
    logic [31:0] MEM_DO;
    logic [3:0]  MEM_BE;
    logic        MEM_WR;
    logic        MEM_REQ;
    logic [31:0] MEM_DI;
    logic        MEM_ACK;
    logic        TO_ERR;

    modport slave (
        input  CE_R, CE_F, A, DO, BS_N, CS0_N, CS1_N, CS2_N, CS3_N, RD_WR_N, RD_N, WE_N,
        input  MEM_DI, MEM_ACK,
        output DI, WAIT_N, MEM_A, MEM_AREA, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, TO_ERR
    );

    modport master (
        output CE_R, CE_F, A, DO, BS_N, CS0_N, CS1_N, CS2_N, CS3_N, RD_WR_N, RD_N, WE_N,
        output MEM_DI, MEM_ACK,
        input  DI, WAIT_N, MEM_A, MEM_AREA, MEM_DO, MEM_BE, MEM_WR, MEM_REQ, TO_ERR
    );
endinterface

// File: rtl/sh2_ext_bus_bridge.sv
// sh2_ext_bus_bridge: turns SH7604 CS0..CS3 bus cycles into single req/ack memory transactions.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave modport carrying CPU pins, memory port and TO_ERR
//   AREA_EN    : per-area enable mask (bit n = CSn_N)
//   TIMEOUT    : CE_R cycles in BUSY before forced completion, 0 disables
//   TO_DATA    : read data returned on timeout
import sh2_ext_bus_bridge_pkg::*;

module sh2_ext_bus_bridge #(
    parameter logic [3:0]  AREA_EN = 4'b1111,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hFFFFFFFF
) (
    input logic                  CLK,
    input logic                  RST_N,
    sh2_ext_bus_bridge_if.slave  bus
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e        state_q;
    mem_req_t      req_q, req_d;
    logic [31:0]   di_q;
    logic          req_on_q, to_err_q, abort_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cs_n;
    area_t         sel;
    logic          start, cs_hi, ack, to_hit, drop;
    logic          unused_pins;

    assign unused_pins = &{1'b0, bus.CE_F, bus.RD_N};

    assign cs_n  = {bus.CS3_N, bus.CS2_N, bus.CS1_N, bus.CS0_N};
    assign sel   = area_enc(~cs_n & AREA_EN);
    assign start = !bus.BS_N && sel.valid;
    assign cs_hi = cs_n[req_q.area];
    assign ack   = bus.MEM_ACK && req_on_q;
    // Saturating increment; timeout fires on the edge the counter would reach TIMEOUT.
    assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign to_hit = (TIMEOUT != 0) && !ack && (cnt_d == CW'(TIMEOUT));
    // Select released during BUSY: finish quietly and skip DONE.
    assign drop   = abort_q || cs_hi;

    assign req_d.a    = bus.A;
    assign req_d.area = sel.idx;
    assign req_d.dout = bus.DO;
    assign req_d.wr   = !bus.RD_WR_N;
    assign req_d.be   = !bus.RD_WR_N ? ~bus.WE_N : 4'hF;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            req_q    <= '0;
            req_on_q <= 1'b0;
            di_q     <= '0;
            to_err_q <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (bus.CE_R) begin
            to_err_q <= 1'b0;
            if (state_q == BUSY) begin
                cnt_q   <= cnt_d;
                abort_q <= abort_q | cs_hi;
                if (ack || to_hit) begin
                    req_on_q <= 1'b0;
                    to_err_q <= to_hit;
                    if (!req_q.wr && !drop)
                        di_q <= ack ? bus.MEM_DI : TO_DATA;
                    state_q <= drop ? IDLE : DONE;
                end
            end else if (start) begin
                // start implies BS_N low, so this also covers the back-to-back case from DONE
                req_q    <= req_d;
                req_on_q <= 1'b1;
                cnt_q    <= '0;
                abort_q  <= 1'b0;
                state_q  <= BUSY;
            end else if (state_q == DONE && (cs_hi || !bus.BS_N)) begin
                state_q <= IDLE;
            end
        end
    end

    assign bus.WAIT_N   = !((state_q == IDLE && start) || state_q == BUSY);
    assign bus.DI       = di_q;
    assign bus.MEM_A    = req_q.a;
    assign bus.MEM_AREA = req_q.area;
    assign bus.MEM_DO   = req_q.dout;
    assign bus.MEM_BE   = req_q.be;
    assign bus.MEM_WR   = req_q.wr;
    assign bus.MEM_REQ  = req_on_q;
    assign bus.TO_ERR   = to_err_q;

endmodule

// File: tb/tb_sh2_ext_bus_bridge.sv
// tb_sh2_ext_bus_bridge: scoreboard bench for sh2_ext_bus_bridge (AREA_EN=0111, TIMEOUT=8).
module tb_sh2_ext_bus_bridge;

    localparam logic [3:0]  AREA_EN = 4'b0111;
    localparam int          TMO     = 8;
    localparam logic [31:0] TO_DATA = 32'hFFFFFFFF;

    typedef struct {
        logic [31:0] di;
        int          wcyc;
        int          rcyc;
        int          to;
    } done_t;

    logic CLK, RST_N;
    sh2_ext_bus_bridge_if bus();

    sh2_ext_bus_bridge #(.AREA_EN(AREA_EN), .TIMEOUT(TMO), .TO_DATA(TO_DATA)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
    );

    int          checks = 0, failures = 0;
    logic [65:0] exp_req_q[$];
    done_t       exp_done_q[$];
    logic [31:0] exp_di = '0;
    int          ack_delay = 0;
    logic [31:0] ack_data = '0;
    logic        mdl_ack = 1'b0, ack_force = 1'b0;

    assign bus.MEM_ACK = mdl_ack | ack_force;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cs(input logic [3:0] v);
        {bus.CS3_N, bus.CS2_N, bus.CS1_N, bus.CS0_N} = v;
    endtask

    // Memory model: acks in the ack_delay-th cycle of MEM_REQ (0 = never).
    initial begin
        int rcy = 0;
        bus.MEM_DI = '0;
        forever begin
            @(posedge CLK); #1;
            if (bus.MEM_REQ) begin
                rcy++;
                mdl_ack = (ack_delay != 0) && (rcy == ack_delay);
                bus.MEM_DI = ack_data;
            end else begin
                rcy = 0;
                mdl_ack = 1'b0;
            end
        end
    end

    // Monitor: request fields on MEM_REQ rise, completion summary on WAIT_N rise.
    initial begin
        int wcnt = 0, rcnt = 0, tcnt = 0;
        logic pw = 1'b1, pr = 1'b0;
        logic [65:0] er;
        done_t ed;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                wcnt = 0; rcnt = 0; tcnt = 0; pw = 1'b1; pr = 1'b0;
            end else begin
                if (!bus.WAIT_N) wcnt++;
                if (bus.MEM_REQ) rcnt++;
                if (bus.TO_ERR) tcnt++;
                if (bus.MEM_REQ && !pr) begin
                    if (exp_req_q.size() == 0) begin
                        chk("unexpected_req", 66'(exp_req_q.size()), 66'(1));
                    end else begin
                        er = exp_req_q.pop_front();
                        chk("req_fields", {bus.MEM_A, bus.MEM_AREA, bus.MEM_DO, bus.MEM_BE, bus.MEM_WR}, er);
                    end
                end
                if (bus.WAIT_N && !pw) begin
                    if (exp_done_q.size() == 0) begin
                        chk("unexpected_wait", 66'(exp_done_q.size()), 66'(1));
                    end else begin
                        ed = exp_done_q.pop_front();
                        chk("di", 66'(bus.DI), 66'(ed.di));
                        chk("wait_cycles", 66'(wcnt), 66'(ed.wcyc));
                        chk("req_cycles", 66'(rcnt), 66'(ed.rcyc));
                        chk("to_err_pulses", 66'(tcnt), 66'(ed.to));
                    end
                    wcnt = 0; rcnt = 0; tcnt = 0;
                end
                pw = bus.WAIT_N;
                pr = bus.MEM_REQ;
            end
        end
    end

    // One CPU bus cycle; entered and left at posedge+#1.
    task automatic issue(input int area, input bit wr, input logic [26:0] a, input logic [31:0] d,
                         input logic [3:0] we, input int dly, input logic [31:0] data,
                         input bit b2b, input bit abort);
        bit en, tmo;
        int n;
        logic [3:0] be;
        done_t r;
        en  = AREA_EN[area];
        tmo = (dly == 0) || (dly > TMO);
        be  = wr ? ~we : 4'hF;
        bus.BS_N = 1'b0;
        set_cs(~(4'b0001 << area));
        bus.RD_WR_N = !wr;
        bus.A = a;
        bus.DO = d;
        bus.WE_N = we;
        ack_delay = dly;
        ack_data = data;
        if (en) begin
            exp_req_q.push_back({a, 2'(area), d, be, wr});
            if (!wr && !abort) exp_di = tmo ? TO_DATA : data;
            r.di   = exp_di;
            r.rcyc = tmo ? TMO : dly;
            r.wcyc = r.rcyc + (b2b ? 0 : 1);
            r.to   = tmo ? 1 : 0;
            exp_done_q.push_back(r);
        end
        #1 chk("wait_t1", 66'(bus.WAIT_N), 66'(!(en && !b2b)));
        @(posedge CLK); #1;
        bus.BS_N = 1'b1;
        bus.A = ~a;
        bus.DO = ~d;
        bus.WE_N = ~we;
        chk("req_next_cycle", 66'(bus.MEM_REQ), 66'(en));
        if (abort) begin
            @(posedge CLK); #1;
            set_cs(4'hF);
        end
        n = 0;
        while (!bus.WAIT_N && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("wait_release_bound", 66'(n >= 40), 66'(0));
    endtask

    task automatic idle();
        set_cs(4'hF);
        bus.BS_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        bus.CE_R = 1'b1;
        bus.CE_F = 1'b0;
        bus.A = '0;
        bus.DO = '0;
        bus.BS_N = 1'b1;
        set_cs(4'hF);
        bus.RD_WR_N = 1'b1;
        bus.RD_N = 1'b1;
        bus.WE_N = 4'hF;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_di", 66'(bus.DI), 66'(0));
        chk("rst_wait_n", 66'(bus.WAIT_N), 66'(1));
        chk("rst_req", 66'(bus.MEM_REQ), 66'(0));
        chk("rst_be_wr", 66'({bus.MEM_BE, bus.MEM_WR, bus.MEM_AREA}), 66'(0));
        chk("rst_to_err", 66'(bus.TO_ERR), 66'(0));
        RST_N = 1'b1;
        @(posedge CLK); #1;

        issue(0, 1'b0, 27'h0000100, 32'h0, 4'hF, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        idle();
        issue(2, 1'b1, 27'h0000200, 32'h00AB0000, 4'b1101, 2, 32'h12345678, 1'b0, 1'b0);
        idle();
        issue(1, 1'b0, 27'h0000300, 32'h0, 4'hF, 0, 32'h55555555, 1'b0, 1'b0);
        idle();
        issue(0, 1'b0, 27'h0000400, 32'h0, 4'hF, 8, 32'hCAFEF00D, 1'b0, 1'b0);
        idle();
        issue(0, 1'b0, 27'h0000500, 32'h0, 4'hF, 1, 32'h11111111, 1'b0, 1'b0);
        issue(1, 1'b0, 27'h0000600, 32'h0, 4'hF, 2, 32'h22222222, 1'b1, 1'b0);
        idle();
        issue(1, 1'b1, 27'h7FFFFFF, 32'hA5A5A5A5, 4'hF, 1, 32'h33333333, 1'b0, 1'b0);
        idle();
        issue(3, 1'b0, 27'h0000700, 32'h0, 4'hF, 2, 32'h44444444, 1'b0, 1'b0);
        idle();
        issue(2, 1'b0, 27'h0000800, 32'h0, 4'hF, 4, 32'hBAD0BAD0, 1'b0, 1'b1);
        idle();
        issue(0, 1'b0, 27'h0000900, 32'h0, 4'hF, 2, 32'h66666666, 1'b0, 1'b0);
        idle();

        // Reset while a request is outstanding, then a stray acknowledge.
        bus.BS_N = 1'b0;
        set_cs(4'b1110);
        bus.RD_WR_N = 1'b1;
        bus.A = 27'h0000A00;
        bus.DO = '0;
        ack_delay = 0;
        exp_req_q.push_back({27'h0000A00, 2'd0, 32'h0, 4'hF, 1'b0});
        @(posedge CLK); #1;
        bus.BS_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("busy_before_rst", 66'(bus.MEM_REQ), 66'(1));
        RST_N = 1'b0;
        #1;
        chk("rst_mid_req", 66'(bus.MEM_REQ), 66'(0));
        chk("rst_mid_wait_n", 66'(bus.WAIT_N), 66'(1));
        chk("rst_mid_di", 66'(bus.DI), 66'(0));
        @(negedge CLK);
        @(posedge CLK); #1;
        set_cs(4'hF);
        RST_N = 1'b1;
        ack_force = 1'b1;
        @(posedge CLK); #1;
        ack_force = 1'b0;
        @(posedge CLK); #1;
        chk("late_ack_req", 66'(bus.MEM_REQ), 66'(0));
        chk("late_ack_wait_n", 66'(bus.WAIT_N), 66'(1));
        chk("late_ack_di", 66'(bus.DI), 66'(0));
        chk("late_ack_to_err", 66'(bus.TO_ERR), 66'(0));
        repeat (2) @(posedge CLK);
        #1;
        chk("req_queue_empty", 66'(exp_req_q.size()), 66'(0));
        chk("done_queue_empty", 66'(exp_done_q.size()), 66'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
